// File: rtl/cpu_stage_sequencer.sv
// Cycle-level step sequencer for the E0C6S46-compatible core: RUN instruction steps,
// interrupt entry and HALT sleep/wake, with step strobes decoded for the datapath.
module cpu_stage_sequencer #(
    parameter logic [3:0] IRQ_CYCLES      = 4'd12,
    parameter logic [3:0] IRQ_WAKE_CYCLES = 4'd13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic       instr_long,
    input  logic       halt_req,
    input  logic       ei_exec,
    input  logic       irq_pending,
    input  logic       irq_enable,
    output logic [1:0] state,
    output logic [3:0] step,
    output logic       fetch_en,
    output logic       decode_en,
    output logic       final_stage,
    output logic       instr_done,
    output logic       irq_ack,
    output logic [3:0] cycle_len
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IRQ  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam logic [3:0] SHORT_LEN = 4'd5;
    localparam logic [3:0] LONG_LEN  = 4'd7;

    seq_state_t state_r, state_s;
    logic [3:0] step_r, step_s;
    logic [3:0] len_r, len_s;
    logic       last_s;
    logic       take_irq_s;
    logic       ei_block_s;

    assign last_s = (step_r == (len_r - 4'd1));
    // An EI committing in this final stage holds off interrupt entry by one instruction.
    assign ei_block_s = ei_exec;
    assign take_irq_s = irq_pending & irq_enable & ~ei_block_s;

    // State, step and sequence-length registers; frozen while clk_en is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_RUN;
            step_r  <= 4'd0;
            len_r   <= SHORT_LEN;
        end else if (clk_en) begin
            state_r <= state_s;
            step_r  <= step_s;
            len_r   <= len_s;
        end else begin
            state_r <= state_r;
            step_r  <= step_r;
            len_r   <= len_r;
        end
    end

    // Next-state, next-step and next-length decision for one enabled cycle.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        len_s   = len_r;
        case (state_r)
            ST_RUN: begin
                if (last_s) begin
                    step_s = 4'd0;
                    if (halt_req) begin
                        state_s = ST_HALT;
                        len_s   = SHORT_LEN;
                    end else if (take_irq_s) begin
                        state_s = ST_IRQ;
                        len_s   = IRQ_CYCLES;
                    end else begin
                        state_s = ST_RUN;
                        len_s   = SHORT_LEN;
                    end
                end else begin
                    step_s = step_r + 4'd1;
                    if (step_r == 4'd1) begin
                        len_s = instr_long ? LONG_LEN : SHORT_LEN;
                    end else begin
                        len_s = len_r;
                    end
                end
            end
            ST_IRQ: begin
                if (last_s) begin
                    state_s = ST_RUN;
                    step_s  = 4'd0;
                    len_s   = SHORT_LEN;
                end else begin
                    step_s = step_r + 4'd1;
                end
            end
            ST_HALT: begin
                step_s = 4'd0;
                // Wake on any pending flag; the I flag only selects IRQ entry versus plain resume.
                if (irq_pending) begin
                    if (irq_enable) begin
                        state_s = ST_IRQ;
                        len_s   = IRQ_WAKE_CYCLES;
                    end else begin
                        state_s = ST_RUN;
                        len_s   = SHORT_LEN;
                    end
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_RUN;
                step_s  = 4'd0;
                len_s   = SHORT_LEN;
            end
        endcase
    end

    assign state       = state_r;
    assign step        = step_r;
    assign cycle_len   = len_r;
    assign fetch_en    = (state_r == ST_RUN) && (step_r == 4'd0);
    assign decode_en   = (state_r == ST_RUN) && (step_r == 4'd1);
    assign final_stage = (state_r == ST_RUN) && last_s;
    assign instr_done  = clk_en && last_s && ((state_r == ST_RUN) || (state_r == ST_IRQ));
    assign irq_ack     = (state_r == ST_IRQ) && (step_r == 4'd0);

endmodule

// File: doc/cpu_stage_sequencer.md
# cpu_stage_sequencer

Cycle-level controller for the E0C6S46-compatible CPU core. It sequences every instruction through its fetch, decode, execute and final-stage steps, and chooses between the 5-cycle and 7-cycle instruction lengths. It also schedules interrupt entry and HALT sleep/wake. It sits between the clock-enable generator and the core's datapath/register file, which consume its step strobes.

## Interface
Parameters:
- IRQ_CYCLES, 12, length in enabled cycles of interrupt entry from RUN
- IRQ_WAKE_CYCLES, 13, length of interrupt entry when waking from HALT

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- clk_en  in  1  CPU cycle enable; all state advances only when high
- instr_long  in  1  decoder: current opcode is a 7-cycle instruction; sampled at step 1
- halt_req  in  1  datapath: HALT/SLP executing; sampled at final stage
- ei_exec  in  1  datapath: EI executing; sampled at final stage
- irq_pending  in  1  any unmasked interrupt flag set
- irq_enable  in  1  I flag
- state  out  2  0=RUN, 1=IRQ, 2=HALT
- step  out  4  step index within current instruction/IRQ sequence
- fetch_en  out  1  RUN and step==0: drive PC onto program bus
- decode_en  out  1  RUN and step==1: latch opcode into decoder
- final_stage  out  1  RUN and step==last: commit PC (increment or jump), register writes
- instr_done  out  1  one clk_en-qualified cycle, coincident with last step of RUN or IRQ
- irq_ack  out  1  IRQ and step==0: clear highest-priority flag, clear I
- cycle_len  out  4  length of current sequence (5, 7, 12 or 13)

## Operation
- Counter `step` increments on each clk with clk_en=1; wraps to 0 at cycle_len-1.
- RUN: cycle_len=5 at step 0. At step 1, with clk_en=1, cycle_len is set to 7 if instr_long=1, else 5. The final step is therefore 4 or 6.
- Transition at the end of the final RUN step, with clk_en=1, by priority:
  1. halt_req=1 -> HALT, step=0.
  2. irq_pending & irq_enable & !ei_block -> IRQ, cycle_len=IRQ_CYCLES.
  3. Otherwise RUN, step 0.
- ei_block:
  - Set when ei_exec=1 at the final stage.
  - Cleared at the final stage of the next instruction.
  - Effect: an interrupt is never taken immediately after EI.
- IRQ:
  - Steps run 0..cycle_len-1; irq_ack is high at step 0 only.
  - The datapath uses step to push PCP/PCS and load the vector.
  - At the last step -> RUN, step 0, cycle_len=5. Interrupts are not re-taken before one instruction completes (the I flag is cleared by the ack).
- HALT:
  - step holds at 0; all strobes are low.
  - Exits on irq_pending=1 (irq_enable is ignored for the wake decision).
  - If irq_enable=1 -> IRQ with cycle_len=IRQ_WAKE_CYCLES; else -> RUN step 0.
- Strobes are decoded combinationally from the registered state/step. Datapath consumers qualify them with clk_en.
- step/cycle_len width is 4 bits; the maximum value of 13 fits, and no overflow path exists.

## Timing
- Reset (reset_n=0 at a clk edge, regardless of clk_en): state=RUN, step=0, cycle_len=5, ei_block=0.
  - Derived outputs: fetch_en=1, decode_en=0, final_stage=0, instr_done=0, irq_ack=0.
- The first instruction begins fetch on the first clk_en after reset deasserts.
- Reset mid-IRQ or mid-HALT aborts immediately to the reset state; no partial ack is repeated.
- clk_en=0 freezes all registers. Outputs stay stable and are not re-pulsed.
- instr_long, halt_req and ei_exec are ignored outside their sampling step.
- irq_pending rising during a non-final step has no effect until the final step.
- Simultaneous halt_req and an interruptible irq at the final stage: HALT is entered, then woken on the next enabled cycle with the 13-cycle entry.
- Latency from the final RUN step to irq_ack: 1 enabled cycle.

## Test plan
- 5-cycle instruction: clk_en=1 continuously, instr_long=0 -> final_stage at step 4, instr_done once, next fetch_en 5 enabled cycles after the previous one; cycle_len=5.
- 7-cycle instruction with clk_en high every 4th clk: instr_long=1 at step 1 -> final_stage at step 6, exactly 7 enabled cycles (28 clks) per instruction.
- Interrupt entry: irq_pending=1, irq_enable=1 during a 5-cycle instruction -> state=IRQ after the final step, irq_ack for one enabled cycle, cycle_len=12, RUN step 0 after 12 enabled cycles.
- EI delay: ei_exec=1 at the final stage with irq_pending=1, irq_enable=1 -> next instruction runs fully (RUN, 5 cycles), IRQ is entered after it.
- HALT wake: halt_req=1 at the final stage -> HALT, step stays 0 for 20 cycles. irq_pending=1, irq_enable=1 -> IRQ with cycle_len=13. Repeat with irq_enable=0 -> RUN step 0, no irq_ack.
- Reset mid-IRQ: reset_n=0 at IRQ step 6 -> next clk state=RUN, step=0, cycle_len=5, irq_ack=0.
